// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared types for the LEGv8 decode stage: operation and format enums, the
// opcode constants for each opcode width, and the decoded-entry struct that is
// stored in the decode-stage output queue.
// -----------------------------------------------------------------------------
package legv8_pkg;

  typedef enum logic [5:0] {
    OP_NONE  = 6'd0,
    OP_B     = 6'd1,
    OP_BL    = 6'd2,
    OP_ORRI  = 6'd3,
    OP_EORI  = 6'd4,
    OP_ADDI  = 6'd5,
    OP_ANDI  = 6'd6,
    OP_ADDIS = 6'd7,
    OP_SUBI  = 6'd8,
    OP_SUBIS = 6'd9,
    OP_ANDIS = 6'd10,
    OP_AND   = 6'd11,
    OP_ADD   = 6'd12,
    OP_ORR   = 6'd13,
    OP_ADDS  = 6'd14,
    OP_EOR   = 6'd15,
    OP_SUB   = 6'd16,
    OP_LSR   = 6'd17,
    OP_LSL   = 6'd18,
    OP_BR    = 6'd19,
    OP_ANDS  = 6'd20,
    OP_SUBS  = 6'd21
  } op_e;

  typedef enum logic [1:0] {
    FMT_R    = 2'd0,
    FMT_I    = 2'd1,
    FMT_B    = 2'd2,
    FMT_NONE = 2'd3
  } fmt_e;

  // 6-bit opcodes, instr[31:26]
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [5:0]  OPC_BL    = 6'b100101;

  // 10-bit opcodes, instr[31:22]
  localparam logic [9:0]  OPC_ORRI  = 10'b1011001000;
  localparam logic [9:0]  OPC_EORI  = 10'b1101001000;
  localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OPC_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OPC_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OPC_SUBIS = 10'b1111000100;
  localparam logic [9:0]  OPC_ANDIS = 10'b1111001000;

  // 11-bit opcodes, instr[31:21]
  localparam logic [10:0] OPC_AND   = 11'b10001010000;
  localparam logic [10:0] OPC_ADD   = 11'b10001011000;
  localparam logic [10:0] OPC_ORR   = 11'b10101010000;
  localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
  localparam logic [10:0] OPC_EOR   = 11'b11001010000;
  localparam logic [10:0] OPC_SUB   = 11'b11001011000;
  localparam logic [10:0] OPC_LSR   = 11'b11010011010;
  localparam logic [10:0] OPC_LSL   = 11'b11010011011;
  localparam logic [10:0] OPC_BR    = 11'b11010110000;
  localparam logic [10:0] OPC_ANDS  = 11'b11101010000;
  localparam logic [10:0] OPC_SUBS  = 11'b11101011000;

  // The queue word carries the widest legal immediate; narrower builds use
  // only the low DATA_W bits.
  localparam int IMM_W = 64;

  typedef struct packed {
    op_e              op;
    fmt_e             fmt;
    logic [4:0]       rd;
    logic [4:0]       rn;
    logic [4:0]       rm;
    logic [5:0]       shamt;
    logic [IMM_W-1:0] imm;
    logic             illegal;
  } dec_entry_t;

endpackage

// File: rtl/legv8_decode_stage_if.sv
// -----------------------------------------------------------------------------
// legv8_decode_stage_if
// Handshake bundle of the decode stage: instruction input side (in_valid /
// in_ready / in_instr) and decoded output side (out_valid / out_ready / out_*).
//   slave  : the decode stage itself
//   master : the environment (fetch upstream, register read downstream)
// -----------------------------------------------------------------------------
interface legv8_decode_stage_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_op;
  logic [1:0]        out_fmt;
  logic [4:0]        out_rd;
  logic [4:0]        out_rn;
  logic [4:0]        out_rm;
  logic [5:0]        out_shamt;
  logic [DATA_W-1:0] out_imm;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_op, out_fmt, out_rd, out_rn, out_rm,
           out_shamt, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_op, out_fmt, out_rd, out_rn, out_rm,
           out_shamt, out_imm, out_illegal
  );
endinterface

// File: rtl/legv8_opdecode.sv
// -----------------------------------------------------------------------------
// legv8_opdecode
// Purely combinational LEGv8 opcode decoder. Classifies instr_i by its 11-bit,
// then 10-bit, then 6-bit opcode (first match wins) and extracts register,
// shift and immediate fields into a dec_entry_t.
//   instr_i : 32-bit instruction word
//   entry_o : decoded entry (op, fmt, rd, rn, rm, shamt, imm, illegal)
// -----------------------------------------------------------------------------
module legv8_opdecode
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0] instr_i,
  output dec_entry_t  entry_o
);

  op_e               op11;
  op_e               op10;
  op_e               op6;
  logic [DATA_W-1:0] imm_b;

  // Sign-extend imm26 to DATA_W first, then scale to a byte offset; bits
  // shifted out of the top are dropped.
  assign imm_b = {{(DATA_W-26){instr_i[25]}}, instr_i[25:0]} << 2;

  always_comb begin
    // NOTE: every variable gets a default before the case statements so no
    // path leaves it unassigned and no latch is inferred.
    op11 = OP_NONE;
    op10 = OP_NONE;
    op6  = OP_NONE;

    case (instr_i[31:21])
      OPC_AND:  op11 = OP_AND;
      OPC_ADD:  op11 = OP_ADD;
      OPC_ORR:  op11 = OP_ORR;
      OPC_ADDS: op11 = OP_ADDS;
      OPC_EOR:  op11 = OP_EOR;
      OPC_SUB:  op11 = OP_SUB;
      OPC_LSR:  op11 = OP_LSR;
      OPC_LSL:  op11 = OP_LSL;
      OPC_BR:   op11 = OP_BR;
      OPC_ANDS: op11 = OP_ANDS;
      OPC_SUBS: op11 = OP_SUBS;
      default:  op11 = OP_NONE;
    endcase

    case (instr_i[31:22])
      OPC_ORRI:  op10 = OP_ORRI;
      OPC_EORI:  op10 = OP_EORI;
      OPC_ADDI:  op10 = OP_ADDI;
      OPC_ANDI:  op10 = OP_ANDI;
      OPC_ADDIS: op10 = OP_ADDIS;
      OPC_SUBI:  op10 = OP_SUBI;
      OPC_SUBIS: op10 = OP_SUBIS;
      OPC_ANDIS: op10 = OP_ANDIS;
      default:   op10 = OP_NONE;
    endcase

    case (instr_i[31:26])
      OPC_B:   op6 = OP_B;
      OPC_BL:  op6 = OP_BL;
      default: op6 = OP_NONE;
    endcase

    // Register and shift fields are raw bit slices regardless of format.
    entry_o.rd      = instr_i[4:0];
    entry_o.rn      = instr_i[9:5];
    entry_o.rm      = instr_i[20:16];
    entry_o.shamt   = instr_i[15:10];
    entry_o.op      = OP_NONE;
    entry_o.fmt     = FMT_NONE;
    entry_o.imm     = '0;
    entry_o.illegal = 1'b1;

    if (op11 != OP_NONE) begin
      entry_o.op      = op11;
      entry_o.fmt     = FMT_R;
      entry_o.illegal = 1'b0;
    end else if (op10 != OP_NONE) begin
      entry_o.op      = op10;
      entry_o.fmt     = FMT_I;
      entry_o.imm     = IMM_W'(instr_i[21:10]);
      entry_o.illegal = 1'b0;
    end else if (op6 != OP_NONE) begin
      entry_o.op      = op6;
      entry_o.fmt     = FMT_B;
      entry_o.imm     = IMM_W'(imm_b);
      entry_o.illegal = 1'b0;
    end
  end

endmodule

// File: rtl/legv8_decode_stage.sv
// -----------------------------------------------------------------------------
// legv8_decode_stage
// Pipelined LEGv8 decode stage between fetch and register read. Decodes each
// accepted instruction word and buffers the result in a DEPTH-entry circular
// queue; out_* always present the registered queue head.
//   clk, rst_n  : clock, asynchronous active-low reset (flushes the queue)
//   bus (slave) : in_valid/in_ready/in_instr and out_valid/out_ready/out_*
//   illegal_cnt : saturating count of accepted illegal words; present only
//                 when LEGV8_DECODE_ILLEGAL_CNT_EN is defined
// Parameters: DATA_W (32 or 64) immediate width, DEPTH (power of two, >= 2).
// -----------------------------------------------------------------------------
module legv8_decode_stage
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  legv8_decode_stage_if.slave  bus
`ifdef LEGV8_DECODE_ILLEGAL_CNT_EN
  ,
  output logic [15:0]          illegal_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dec_entry_t       dec;
  dec_entry_t       mem_q [DEPTH];
  dec_entry_t       head_q, head_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remain;
  logic             out_valid_q, in_ready_q;
  logic             push, pop;

  legv8_opdecode #(.DATA_W(DATA_W)) u_opdecode (
    .instr_i (bus.in_instr),
    .entry_o (dec)
  );

  assign push = bus.in_valid && in_ready_q;
  assign pop  = bus.out_ready && out_valid_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Entries left after this cycle's pop. If none remain, the new head can
    // only be the word being pushed now (it is not in storage yet); otherwise
    // it already sits in storage at the next read pointer. With nothing left
    // and nothing pushed, the head register keeps its last value.
    remain = count_q - CNT_W'(pop);
    if (remain == '0) begin
      if (push) begin
        head_d = dec;
      end
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: queue storage has no reset; the pointers and count define which
  // entries are meaningful, and the head register supplies reset values.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      out_valid_q <= (count_d != '0);
      in_ready_q  <= (count_d != CNT_W'(DEPTH));
    end
  end

`ifdef LEGV8_DECODE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (push && dec.illegal && (illegal_cnt_q != 16'hFFFF)) begin
      illegal_cnt_q <= illegal_cnt_q + 1'b1;
    end
  end

  assign illegal_cnt = illegal_cnt_q;
`endif

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op      = head_q.op;
  assign bus.out_fmt     = head_q.fmt;
  assign bus.out_rd      = head_q.rd;
  assign bus.out_rn      = head_q.rn;
  assign bus.out_rm      = head_q.rm;
  assign bus.out_shamt   = head_q.shamt;
  assign bus.out_imm     = head_q.imm[DATA_W-1:0];
  assign bus.out_illegal = head_q.illegal;

endmodule
